// File: rtl/sample_fetch_ctl_if.sv
// Request, RAM-side and response signals of the sample fetch controller.
// The slave modport is the controller's view; the master modport is its environment.
interface sample_fetch_ctl_if #(
    parameter int ADDR_W   = 20,
    parameter int ID_W     = 6,
    parameter int FIFO_LG2 = 5
);
    logic                req_available;
    logic [ADDR_W-1:0]   address_in;
    logic [ID_W-1:0]     r_id_in;
    logic                flush;
    logic                ram_busy;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_rd_en;
    logic [15:0]         ram_rd_data;
    logic [15:0]         data_out;
    logic [ID_W-1:0]     r_id_out;
    logic                data_ready;
    logic [FIFO_LG2:0]   fifo_count;
    logic                overflow;

    modport slave (
        input  req_available, address_in, r_id_in, flush, ram_busy, ram_rd_data,
        output ram_addr, ram_rd_en, data_out, r_id_out, data_ready, fifo_count, overflow
    );

    modport master (
        output req_available, address_in, r_id_in, flush, ram_busy, ram_rd_data,
        input  ram_addr, ram_rd_en, data_out, r_id_out, data_ready, fifo_count, overflow
    );
endinterface

// File: rtl/sample_fetch_ctl.sv
// Read controller between playback slots and sample RAM: request FIFO, registered RAM
// issue, and a tag pipe that pairs each returning RAM word with its slot id.
module sample_fetch_ctl #(
    parameter int ADDR_W   = 20,
    parameter int ID_W     = 6,
    parameter int FIFO_LG2 = 5,
    parameter int RAM_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_fetch_ctl_if.slave    bus
);
    localparam int DEPTH = 1 << FIFO_LG2;
    localparam logic [FIFO_LG2:0]   FULL_CNT = (FIFO_LG2+1)'(DEPTH);
    localparam logic [FIFO_LG2:0]   CNT_ONE  = (FIFO_LG2+1)'(1);
    localparam logic [FIFO_LG2-1:0] PTR_ONE  = FIFO_LG2'(1);

    logic [ADDR_W+ID_W-1:0] fifo_mem [DEPTH];

    logic [FIFO_LG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LG2:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [ID_W-1:0]     issue_id_q, issue_id_d;
    logic [RAM_LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]     tag_id_q [RAM_LAT];
    logic [ID_W-1:0]     tag_id_d [RAM_LAT];
    logic                data_ready_q, data_ready_d;
    logic [15:0]         data_out_q, data_out_d;
    logic [ID_W-1:0]     r_id_out_q, r_id_out_d;

    logic                empty, full, push, pop;
    logic [ADDR_W+ID_W-1:0] head;

    // FIFO control; a flush re-bases the read pointer onto the write pointer.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        head     = fifo_mem[rd_ptr_q];
        pop      = !empty && !bus.ram_busy && !bus.flush;
        push     = bus.req_available && (bus.flush || !full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = push ? CNT_ONE : '0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)
                count_d = count_q + CNT_ONE;
            else if (!push && pop)
                count_d = count_q - CNT_ONE;
        end
        overflow_d  = overflow_q | (bus.req_available & ~push);
        ram_rd_en_d = pop;
        ram_addr_d  = ram_addr_q;
        issue_id_d  = issue_id_q;
        if (pop) begin
            ram_addr_d = head[ID_W +: ADDR_W];
            issue_id_d = head[ID_W-1:0];
        end
    end

    // Stage 0 follows the registered read strobe, so the tail lines up with ram_rd_data.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = ram_rd_en_q & ~bus.flush;
        tag_id_d[0]  = issue_id_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] & ~bus.flush;
            tag_id_d[i]  = tag_id_q[i-1];
        end
        data_ready_d = tag_vld_q[RAM_LAT-1] & ~bus.flush;
        data_out_d   = data_ready_d ? bus.ram_rd_data : data_out_q;
        r_id_out_d   = data_ready_d ? tag_id_q[RAM_LAT-1] : r_id_out_q;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.address_in, bus.r_id_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            ram_rd_en_q  <= 1'b0;
            ram_addr_q   <= '0;
            issue_id_q   <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < RAM_LAT; i++)
                tag_id_q[i] <= '0;
            data_ready_q <= 1'b0;
            data_out_q   <= '0;
            r_id_out_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ram_rd_en_q  <= ram_rd_en_d;
            ram_addr_q   <= ram_addr_d;
            issue_id_q   <= issue_id_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            data_ready_q <= data_ready_d;
            data_out_q   <= data_out_d;
            r_id_out_q   <= r_id_out_d;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_rd_en  = ram_rd_en_q;
    assign bus.data_out   = data_out_q;
    assign bus.r_id_out   = r_id_out_q;
    assign bus.data_ready = data_ready_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule
